// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/mem/wb sequencing.
// Ports: clk_i, rst_i (async low), op_i, mem_ready_i -> datapath controls,
// alu_op_o, illegal_o, state_o.
// Build option: define MC_JUMP_EN to decode opcode 000010 as a jump.
module multicycle_ctrl #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic            pc_write_cond_o,
  output logic            i_or_d_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            ir_write_o,
  output logic            mem_to_reg_o,
  output logic            reg_write_o,
  output logic            reg_dst_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [2:0]      alu_op_o,
  output logic [1:0]      pc_source_o,
  output logic            illegal_o,
  output logic [ST_W-1:0] state_o
);

  typedef enum logic [ST_W-1:0] {
    IDLE   = ST_W'(0),
    FETCH  = ST_W'(1),
    DECODE = ST_W'(2),
    MEMADR = ST_W'(3),
    MEMRD  = ST_W'(4),
    MEMWB  = ST_W'(5),
    MEMWR  = ST_W'(6),
    EXEC   = ST_W'(7),
    RWB    = ST_W'(8),
    BRANCH = ST_W'(9),
    JUMP   = ST_W'(10),
    IEXEC  = ST_W'(11),
    IWB    = ST_W'(12),
    TRAP   = ST_W'(15)
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
`ifdef MC_JUMP_EN
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
`endif

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic            illegal_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE:  state <= FETCH;
        FETCH: if (mem_ready_i) state <= DECODE;
        DECODE: begin
          op_q <= op_i;
          unique case (1'b1)
            (op_i == OP_R):    state <= EXEC;
            (op_i == OP_LW),
            (op_i == OP_SW):   state <= MEMADR;
            (op_i == OP_BEQ):  state <= BRANCH;
            (op_i == OP_ADDI),
            (op_i == OP_SLTI): state <= IEXEC;
`ifdef MC_JUMP_EN
            (op_i == OP_J):    state <= JUMP;
`endif
            default: begin
              state     <= TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        // Held opcode: op_i is only guaranteed through DECODE.
        MEMADR: state <= (op_q == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready_i) state <= MEMWB;
        MEMWR:  if (mem_ready_i) state <= FETCH;
        EXEC:   state <= RWB;
        IEXEC:  state <= IWB;
        MEMWB,
        RWB,
        IWB,
        BRANCH: state <= FETCH;
`ifdef MC_JUMP_EN
        JUMP:   state <= FETCH;
`endif
        TRAP:   state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 3'b000;
    pc_source_o     = 2'b00;
    unique case (state)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        // PC+4 and IR load only once the fetch completes.
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE: alu_src_b_o = 2'b11;
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      MEMRD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      MEMWR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
      end
      RWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      IEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = (op_q == OP_ADDI) ? 3'b011 : 3'b100;
      end
      IWB: reg_write_o = 1'b1;
      BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = 3'b001;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 2'b01;
      end
`ifdef MC_JUMP_EN
      JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  assign illegal_o = illegal_q;
  assign state_o   = state;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit opcode and sequences instruction fetch, decode, execute, memory and write-back over several cycles.
- Drives every datapath mux/enable and the 3-bit ALUOp consumed by the ALU controller.
- Waits on a single-bit memory-ready handshake so that one shared instruction/data memory can have variable latency.

## Interface

Parameters:
- `OP_W`, default 6: opcode width.
- `ST_W`, default 4: state register width.

Ports:
- `clk_i`, in, 1: clock; all state changes on the rising edge.
- `rst_i`, in, 1: asynchronous, active-low reset.
- `op_i`, in, 6: opcode field `IR[31:26]`; valid from DECODE onward.
- `mem_ready_i`, in, 1: memory completes the current read or write in this cycle.
- `pc_write_o`, out, 1: unconditional PC load.
- `pc_write_cond_o`, out, 1: PC load if ALU zero.
- `i_or_d_o`, out, 1: memory address source; 0 = PC, 1 = ALUOut.
- `mem_read_o`, out, 1: memory read request.
- `mem_write_o`, out, 1: memory write request.
- `ir_write_o`, out, 1: IR load.
- `mem_to_reg_o`, out, 1: write-back source; 1 = MDR.
- `reg_write_o`, out, 1: register-file write.
- `reg_dst_o`, out, 1: destination register; 1 = rd, 0 = rt.
- `alu_src_a_o`, out, 1: ALU A input; 0 = PC, 1 = rs.
- `alu_src_b_o`, out, 2: ALU B input; 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op_o`, out, 3: ALUOp; 000 add, 001 branch subtract, 010 R-type (use funct), 011 addi, 100 slti.
- `pc_source_o`, out, 2: next-PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_o`, out, 1: sticky unsupported-opcode flag.
- `state_o`, out, 4: current state, for debug.

## Operation

States and encodings:
- IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6, EXEC = 7, RWB = 8, BRANCH = 9, JUMP = 10, IEXEC = 11, IWB = 12, TRAP = 15.

Output style:
- Moore outputs per state. Every output not listed for a state is 0.
- Exceptions are the handshake-qualified strobes noted below, which are combinational on `mem_ready_i`.

Per-state behaviour:
- IDLE: all outputs 0. Always → FETCH.
- FETCH:
  - Outputs: `mem_read_o`=1, `i_or_d_o`=0, `alu_src_a_o`=0, `alu_src_b_o`=01, `alu_op_o`=000, `pc_source_o`=00.
  - `ir_write_o` = `pc_write_o` = `mem_ready_i`.
  - Stays in FETCH while `mem_ready_i`=0; → DECODE when it is 1.
- DECODE:
  - Outputs: `alu_src_a_o`=0, `alu_src_b_o`=11, `alu_op_o`=000 (branch-target precompute).
  - Next state by opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 → BRANCH; 001000 or 001010 → IEXEC; 000010 → JUMP (only with the Configuration macro defined); any other opcode → TRAP.
- MEMADR:
  - Outputs: `alu_src_a_o`=1, `alu_src_b_o`=10, `alu_op_o`=000.
  - → MEMRD for 100011, → MEMWR for 101011.
- MEMRD:
  - Outputs: `mem_read_o`=1, `i_or_d_o`=1.
  - Waits for `mem_ready_i`, then → MEMWB.
- MEMWB:
  - Outputs: `reg_write_o`=1, `mem_to_reg_o`=1, `reg_dst_o`=0.
  - → FETCH.
- MEMWR:
  - Outputs: `mem_write_o`=1, `i_or_d_o`=1.
  - Waits for `mem_ready_i`, then → FETCH.
- EXEC:
  - Outputs: `alu_src_a_o`=1, `alu_src_b_o`=00, `alu_op_o`=010.
  - → RWB.
- RWB:
  - Outputs: `reg_write_o`=1, `reg_dst_o`=1.
  - → FETCH.
- IEXEC:
  - Outputs: `alu_src_a_o`=1, `alu_src_b_o`=10.
  - `alu_op_o` = 011 for opcode 001000, 100 for opcode 001010.
  - → IWB.
- IWB:
  - Outputs: `reg_write_o`=1, `reg_dst_o`=0, `mem_to_reg_o`=0.
  - → FETCH.
- BRANCH:
  - Outputs: `alu_src_a_o`=1, `alu_src_b_o`=00, `alu_op_o`=001, `pc_write_cond_o`=1, `pc_source_o`=01.
  - → FETCH.
- JUMP:
  - Outputs: `pc_write_o`=1, `pc_source_o`=10.
  - → FETCH.
- TRAP: all outputs 0. Stays in TRAP until reset.

Illegal-opcode flag:
- `illegal_o` is a register set on the DECODE → TRAP transition.
- Cleared only by reset.

Opcode latching:
- `op_i` is sampled in DECODE and held in an internal 6-bit register.
- MEMADR and IEXEC decisions use the held value, not live `op_i`.

## Timing

Reset:
- `rst_i`=0 forces state to IDLE and `illegal_o` to 0 immediately, with no clock needed.
- Every output reads 0 while in reset, and on the first edge after `rst_i` rises (state IDLE).
- Reset asserted mid-instruction aborts it. No partial write strobe survives past the reset assertion.

Latency with `mem_ready_i` held at 1, counted from FETCH entry to the next FETCH entry:

| Instruction | Cycles |
|---|---|
| R-type | 4 |
| lw | 5 |
| sw | 4 |
| addi / slti | 4 |
| beq | 3 |
| j | 3 |

Memory wait states:
- Each cycle with `mem_ready_i`=0 in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- Request outputs stay stable during the wait.

Handshake rules:
- `mem_ready_i` is ignored in every state other than FETCH, MEMRD and MEMWR.
- `mem_read_o` and `mem_write_o` are never both 1.

## Configuration

Macro `MC_JUMP_EN`:
- Defined: opcode 000010 decodes to JUMP.
- Undefined: opcode 000010 goes to TRAP and sets `illegal_o`. The JUMP state and `pc_source_o`=10 are never produced.

## Test plan

- **Reset:** pulse `rst_i` low mid-MEMWR with `mem_ready_i`=0 → `mem_write_o` drops to 0 asynchronously; `state_o`=0; FETCH is reached 1 cycle after release.
- **R-type, zero-wait:** `op_i`=000000, `mem_ready_i`=1 → `state_o` sequence 1, 2, 7, 8, 1. `alu_op_o`=010 in EXEC; `reg_write_o`=1 with `reg_dst_o`=1 in RWB.
- **lw with wait states:** `op_i`=100011, `mem_ready_i` low for 2 cycles in MEMRD → MEMRD lasts 3 cycles with `mem_read_o`=1 and `i_or_d_o`=1; then MEMWB has `mem_to_reg_o`=1. Total 7 cycles.
- **FETCH stall:** `mem_ready_i`=0 for 3 cycles → `ir_write_o`=0 and `pc_write_o`=0 on those cycles; both are 1 in the ready cycle only.
- **beq and slti:** beq gives BRANCH with `alu_op_o`=001, `pc_write_cond_o`=1, `pc_source_o`=01, 3 cycles total. `op_i`=001010 gives IEXEC with `alu_op_o`=100.
- **Illegal opcode / jump:** `op_i`=111111 → TRAP, `illegal_o`=1, held until reset. `op_i`=000010 → JUMP when `MC_JUMP_EN` is defined; TRAP when it is not.
